// File: rtl/read_path_controller.sv
// Forwards the arbiter-granted master's AR to the slave and returns its R burst.
// AR valid two cycles after grant, R is pass-through; one read in flight, backpressure passes straight through both directions.
module read_path_controller #(
  parameter int Addr_Width      = 32,
  parameter int Data_Width      = 32,
  parameter int Masters_ID_Size = 1
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic                       Channel_Request,
  input  logic [Masters_ID_Size-1:0] Selected_Master,
  output logic                       Channel_Granted,
  output logic                       Token,

  input  logic                       S00_AXI_arvalid,
  input  logic [Addr_Width-1:0]      S00_AXI_araddr,
  input  logic [7:0]                 S00_AXI_arlen,
  input  logic [2:0]                 S00_AXI_arsize,
  input  logic [1:0]                 S00_AXI_arburst,
  output logic                       S00_AXI_arready,
  output logic [Data_Width-1:0]      S00_AXI_rdata,
  output logic [1:0]                 S00_AXI_rresp,
  output logic                       S00_AXI_rlast,
  output logic                       S00_AXI_rvalid,
  input  logic                       S00_AXI_rready,

  input  logic                       S01_AXI_arvalid,
  input  logic [Addr_Width-1:0]      S01_AXI_araddr,
  input  logic [7:0]                 S01_AXI_arlen,
  input  logic [2:0]                 S01_AXI_arsize,
  input  logic [1:0]                 S01_AXI_arburst,
  output logic                       S01_AXI_arready,
  output logic [Data_Width-1:0]      S01_AXI_rdata,
  output logic [1:0]                 S01_AXI_rresp,
  output logic                       S01_AXI_rlast,
  output logic                       S01_AXI_rvalid,
  input  logic                       S01_AXI_rready,

  output logic                       M_AXI_arvalid,
  output logic [Addr_Width-1:0]      M_AXI_araddr,
  output logic [7:0]                 M_AXI_arlen,
  output logic [2:0]                 M_AXI_arsize,
  output logic [1:0]                 M_AXI_arburst,
  input  logic                       M_AXI_arready,
  input  logic [Data_Width-1:0]      M_AXI_rdata,
  input  logic [1:0]                 M_AXI_rresp,
  input  logic                       M_AXI_rlast,
  input  logic                       M_AXI_rvalid,
  output logic                       M_AXI_rready,

  output logic                       Len_Error
);

  typedef enum logic [1:0] {IDLE, SEL, ADDR, DATA} state_t;

  state_t     state_q, state_d;
  logic       sel_q;
  logic [7:0] exp_len_q;
  logic [8:0] beat_cnt_q;
  logic       len_error_q;

  logic       pick;
  logic       pick_arvalid;
  logic [7:0] pick_arlen;
  logic       sel_rready;
  logic       r_hs;
  logic [8:0] beat_cnt_inc;

  assign pick         = Selected_Master[0];
  assign pick_arvalid = pick ? S01_AXI_arvalid : S00_AXI_arvalid;
  assign pick_arlen   = pick ? S01_AXI_arlen   : S00_AXI_arlen;
  assign sel_rready   = sel_q ? S01_AXI_rready : S00_AXI_rready;
  assign r_hs         = (state_q == DATA) && M_AXI_rvalid && sel_rready;
  assign beat_cnt_inc = (beat_cnt_q == 9'd511) ? beat_cnt_q : beat_cnt_q + 9'd1;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      exp_len_q   <= 8'd0;
      beat_cnt_q  <= 9'd0;
      len_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_error_q <= 1'b0;
      if (state_q == SEL) begin
        sel_q      <= pick;
        exp_len_q  <= pick_arlen;
        beat_cnt_q <= 9'd0;
      end
      if (r_hs) begin
        beat_cnt_q <= beat_cnt_inc;
        // Compared against the post-increment count so the last beat is included.
        if (M_AXI_rlast) begin
          len_error_q <= (beat_cnt_inc != ({1'b0, exp_len_q} + 9'd1));
        end
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    Channel_Granted = (state_q == IDLE);
    Token           = (state_q != IDLE);

    M_AXI_arvalid   = 1'b0;
    M_AXI_araddr    = sel_q ? S01_AXI_araddr  : S00_AXI_araddr;
    M_AXI_arlen     = sel_q ? S01_AXI_arlen   : S00_AXI_arlen;
    M_AXI_arsize    = sel_q ? S01_AXI_arsize  : S00_AXI_arsize;
    M_AXI_arburst   = sel_q ? S01_AXI_arburst : S00_AXI_arburst;
    S00_AXI_arready = 1'b0;
    S01_AXI_arready = 1'b0;

    M_AXI_rready    = 1'b0;
    S00_AXI_rdata   = M_AXI_rdata;
    S00_AXI_rresp   = M_AXI_rresp;
    S00_AXI_rlast   = M_AXI_rlast;
    S00_AXI_rvalid  = 1'b0;
    S01_AXI_rdata   = M_AXI_rdata;
    S01_AXI_rresp   = M_AXI_rresp;
    S01_AXI_rlast   = M_AXI_rlast;
    S01_AXI_rvalid  = 1'b0;

    case (state_q)
      IDLE: begin
        if (Channel_Request) state_d = SEL;
      end
      SEL: begin
        state_d = pick_arvalid ? ADDR : IDLE;
      end
      ADDR: begin
        M_AXI_arvalid   = 1'b1;
        S00_AXI_arready = !sel_q && M_AXI_arready;
        S01_AXI_arready =  sel_q && M_AXI_arready;
        if (M_AXI_arready) state_d = DATA;
      end
      DATA: begin
        M_AXI_rready   = sel_rready;
        S00_AXI_rvalid = !sel_q && M_AXI_rvalid;
        S01_AXI_rvalid =  sel_q && M_AXI_rvalid;
        if (r_hs && M_AXI_rlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign Len_Error = len_error_q;

endmodule

// File: tb/tb_read_path_controller.sv
// Randomized read traffic through read_path_controller, checked by queue scoreboards.
`timescale 1ns/1ps
module tb_read_path_controller;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        Channel_Request = 1'b0;
  logic [0:0]  Selected_Master = 1'b0;
  logic        Channel_Granted, Token, Len_Error;

  logic        arvalid [2];
  logic [31:0] araddr  [2];
  logic [7:0]  arlen   [2];
  logic [2:0]  arsize  [2];
  logic [1:0]  arburst [2];
  logic        arready [2];
  logic [31:0] rdata   [2];
  logic [1:0]  rresp   [2];
  logic        rlast   [2];
  logic        rvalid  [2];
  logic        rready  [2];

  logic        M_AXI_arvalid, M_AXI_arready = 1'b0;
  logic [31:0] M_AXI_araddr;
  logic [7:0]  M_AXI_arlen;
  logic [2:0]  M_AXI_arsize;
  logic [1:0]  M_AXI_arburst;
  logic [31:0] M_AXI_rdata = '0;
  logic [1:0]  M_AXI_rresp = '0;
  logic        M_AXI_rlast = 1'b0, M_AXI_rvalid = 1'b0, M_AXI_rready;

  read_path_controller #(.Addr_Width(32), .Data_Width(32), .Masters_ID_Size(1)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .Channel_Request(Channel_Request), .Selected_Master(Selected_Master),
    .Channel_Granted(Channel_Granted), .Token(Token),
    .S00_AXI_arvalid(arvalid[0]), .S00_AXI_araddr(araddr[0]), .S00_AXI_arlen(arlen[0]),
    .S00_AXI_arsize(arsize[0]), .S00_AXI_arburst(arburst[0]), .S00_AXI_arready(arready[0]),
    .S00_AXI_rdata(rdata[0]), .S00_AXI_rresp(rresp[0]), .S00_AXI_rlast(rlast[0]),
    .S00_AXI_rvalid(rvalid[0]), .S00_AXI_rready(rready[0]),
    .S01_AXI_arvalid(arvalid[1]), .S01_AXI_araddr(araddr[1]), .S01_AXI_arlen(arlen[1]),
    .S01_AXI_arsize(arsize[1]), .S01_AXI_arburst(arburst[1]), .S01_AXI_arready(arready[1]),
    .S01_AXI_rdata(rdata[1]), .S01_AXI_rresp(rresp[1]), .S01_AXI_rlast(rlast[1]),
    .S01_AXI_rvalid(rvalid[1]), .S01_AXI_rready(rready[1]),
    .M_AXI_arvalid(M_AXI_arvalid), .M_AXI_araddr(M_AXI_araddr), .M_AXI_arlen(M_AXI_arlen),
    .M_AXI_arsize(M_AXI_arsize), .M_AXI_arburst(M_AXI_arburst), .M_AXI_arready(M_AXI_arready),
    .M_AXI_rdata(M_AXI_rdata), .M_AXI_rresp(M_AXI_rresp), .M_AXI_rlast(M_AXI_rlast),
    .M_AXI_rvalid(M_AXI_rvalid), .M_AXI_rready(M_AXI_rready),
    .Len_Error(Len_Error)
  );

  always #5 ACLK = ~ACLK;

  typedef struct { logic sel; logic [31:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst; } ar_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; logic last; } r_t;

  ar_t ar_q[$];
  r_t  rq0[$], rq1[$];
  bit  le_q[$];

  int total = 0, bad = 0;
  int cyc = 0, last_done = 0;
  bit mon_on = 0, exp_busy = 0, in_data = 0, le_pending = 0;
  int data_m = 0;

  always @(posedge ACLK) cyc++;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: compares everything the DUT presents against the model state.
  always @(negedge ACLK) begin
    ar_t e;
    r_t  b;
    bit  have, got_last;
    if (mon_on) begin
      got_last = 0;
      chk("token", Token, exp_busy);
      chk("granted", Channel_Granted, !exp_busy);
      if (M_AXI_arvalid) begin
        if (ar_q.size() == 0) chk("ar_unexpected", 1, 0);
        else begin
          e = ar_q[0];
          chk("ar_addr", M_AXI_araddr, e.addr);
          chk("ar_len", M_AXI_arlen, e.len);
          chk("ar_size", M_AXI_arsize, e.size);
          chk("ar_burst", M_AXI_arburst, e.burst);
          chk("arready_sel", arready[e.sel ? 1 : 0], M_AXI_arready);
          chk("arready_other", arready[e.sel ? 0 : 1], 0);
          if (M_AXI_arready) void'(ar_q.pop_front());
        end
      end else begin
        chk("arready_idle", arready[0] | arready[1], 0);
      end
      chk("m_rready", M_AXI_rready, in_data ? rready[data_m] : 1'b0);
      for (int x = 0; x < 2; x++) begin
        chk("s_rvalid", rvalid[x], (in_data && data_m == x) ? M_AXI_rvalid : 1'b0);
        if (rvalid[x] && rready[x]) begin
          have = (x == 0) ? (rq0.size() > 0) : (rq1.size() > 0);
          if (!have) chk("r_unexpected", x, 99);
          else begin
            b = (x == 0) ? rq0.pop_front() : rq1.pop_front();
            chk("r_data", rdata[x], b.data);
            chk("r_resp", rresp[x], b.resp);
            chk("r_last", rlast[x], b.last);
            if (rlast[x]) got_last = 1;
          end
        end
      end
      if (le_pending) begin
        if (le_q.size() == 0) chk("le_unexpected", 1, 0);
        else chk("len_error", Len_Error, le_q.pop_front());
      end else begin
        chk("len_error_quiet", Len_Error, 0);
      end
      le_pending = got_last;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge ACLK); #1; end
  endtask

  task automatic do_read(input int m, input int len, input int nbeats, input int ar_wait,
                         input int abort_at, input bit other_vld, input bit chk_gap);
    int o = 1 - m;
    int sent = 0;
    int guard;
    bit accepted;
    ar_t a;
    r_t  b;
    arvalid[m] = 1; araddr[m] = $urandom; arlen[m] = len[7:0];
    arsize[m] = 3'($urandom_range(0, 7)); arburst[m] = 2'($urandom_range(0, 2));
    arvalid[o] = other_vld; araddr[o] = $urandom; arlen[o] = 8'($urandom);
    arsize[o] = 3'($urandom_range(0, 7)); arburst[o] = 2'($urandom_range(0, 3));
    a.sel = m[0]; a.addr = araddr[m]; a.len = arlen[m]; a.size = arsize[m]; a.burst = arburst[m];
    ar_q.push_back(a);
    if (abort_at < 0) le_q.push_back(nbeats != len + 1);
    Channel_Request = 1;
    @(posedge ACLK); #1;
    Channel_Request = 0; Selected_Master = m[0]; exp_busy = 1;
    chk("sel_no_arvalid", M_AXI_arvalid, 0);
    @(posedge ACLK); #1;
    if (chk_gap) chk("b2b_gap", cyc - last_done, 2);
    chk("addr_arvalid", M_AXI_arvalid, 1);
    // Stray slave R traffic while the address is pending must be ignored.
    repeat (ar_wait) begin
      M_AXI_rvalid = 1'($urandom_range(0, 1)); M_AXI_rlast = 1;
      rready[0] = 1; rready[1] = 1;
      @(posedge ACLK); #1;
    end
    M_AXI_rvalid = 0; M_AXI_rlast = 0;
    M_AXI_arready = 1;
    @(posedge ACLK); #1;
    M_AXI_arready = 0; arvalid[m] = 0; arvalid[o] = 0; arlen[m] = 8'($urandom);
    in_data = 1; data_m = m;
    while (sent < nbeats) begin
      if (sent == abort_at) begin
        M_AXI_rvalid = 0; rready[0] = 1; rready[1] = 1; ARESETN = 0;
        @(posedge ACLK); #1;
        ARESETN = 1; exp_busy = 0; in_data = 0;
        chk("rst_granted", Channel_Granted, 1);
        chk("rst_token", Token, 0);
        chk("rst_m_rready", M_AXI_rready, 0);
        return;
      end
      M_AXI_rvalid = 0;
      repeat ($urandom_range(0, 2)) begin
        rready[0] = 1'($urandom_range(0, 1)); rready[1] = 1'($urandom_range(0, 1));
        @(posedge ACLK); #1;
      end
      b.data = $urandom; b.resp = 2'($urandom_range(0, 3)); b.last = (sent == nbeats - 1);
      M_AXI_rvalid = 1; M_AXI_rdata = b.data; M_AXI_rresp = b.resp; M_AXI_rlast = b.last;
      if (m == 0) rq0.push_back(b); else rq1.push_back(b);
      accepted = 0; guard = 0;
      while (!accepted && guard < 60) begin
        rready[0] = 1'($urandom_range(0, 1)); rready[1] = 1'($urandom_range(0, 1));
        @(negedge ACLK);
        accepted = M_AXI_rready;
        @(posedge ACLK); #1;
        guard++;
      end
      if (!accepted) chk("beat_timeout", 0, 1);
      sent++;
    end
    M_AXI_rvalid = 0; M_AXI_rlast = 0;
    exp_busy = 0; in_data = 0; last_done = cyc;
  endtask

  task automatic defensive(input int m);
    arvalid[m] = 0; arvalid[1 - m] = 1;
    Channel_Request = 1;
    @(posedge ACLK); #1;
    Channel_Request = 0; Selected_Master = m[0]; exp_busy = 1;
    @(posedge ACLK); #1;
    exp_busy = 0;
    chk("def_no_arvalid", M_AXI_arvalid, 0);
    arvalid[1 - m] = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    int m, len, nb;
    for (int i = 0; i < 2; i++) begin
      arvalid[i] = 0; araddr[i] = '0; arlen[i] = '0; arsize[i] = '0; arburst[i] = '0; rready[i] = 0;
    end
    ARESETN = 0;
    repeat (3) @(posedge ACLK);
    #1 ARESETN = 1;
    mon_on = 1;
    @(negedge ACLK);
    chk("reset_granted", Channel_Granted, 1);
    chk("reset_token", Token, 0);
    chk("reset_len_error", Len_Error, 0);
    @(posedge ACLK); #1;

    do_read(0, 3, 4, 0, -1, 0, 0);   // plain 4-beat burst from M0
    idle(2);
    do_read(1, 5, 6, 5, -1, 1, 0);   // M1 with slave arready held off
    idle(1);
    do_read(0, 3, 2, 1, -1, 1, 0);   // short burst -> length error
    do_read(1, 3, 4, 0, -1, 0, 0);
    do_read(0, 7, 8, 1, 3, 1, 0);    // reset mid-burst
    do_read(0, 2, 3, 0, -1, 0, 0);
    do_read(1, 1, 2, 0, -1, 1, 1);   // back-to-back, alternating masters
    do_read(0, 0, 1, 2, -1, 0, 1);
    defensive(1);
    idle(1);
    do_read(1, 4, 7, 0, -1, 1, 0);   // long burst -> length error
    for (int i = 0; i < 25; i++) begin
      m   = $urandom_range(0, 1);
      len = $urandom_range(0, 15);
      nb  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 17) : len + 1;
      do_read(m, len, nb, $urandom_range(0, 3), -1, 1'($urandom_range(0, 1)), 0);
      idle($urandom_range(0, 2));
    end
    idle(4);
    chk("ar_q_drained", ar_q.size(), 0);
    chk("r0_drained", rq0.size(), 0);
    chk("r1_drained", rq1.size(), 0);
    chk("le_q_drained", le_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
